// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI slave definitions.
//   spi_state_t - frame state encodings, shared by spi_rx_module and spi_tx_module.
//   SPI_OP_*    - command opcodes recognised in the first byte of a frame.
package spi_pkg;

  typedef enum logic [2:0] {
    SPI_CMD     = 3'b000,
    SPI_ADDR_HB = 3'b001,
    SPI_ADDR_LB = 3'b010,
    SPI_DAT_WR  = 3'b011,
    SPI_DAT_RD  = 3'b100,
    SPI_WAIT    = 3'b101,
    SPI_ERR     = 3'b110
  } spi_state_t;

  localparam logic [7:0] SPI_OP_WRITE = 8'h02;
  localparam logic [7:0] SPI_OP_READ  = 8'h03;
  localparam logic [7:0] SPI_OP_WRDI  = 8'h04;
  localparam logic [7:0] SPI_OP_RDSR  = 8'h05;
  localparam logic [7:0] SPI_OP_WREN  = 8'h06;

endpackage

// File: rtl/spi_rx_module_if.sv
// spi_rx_module_if: signal bundle between the SPI receive half and its peers.
//   slave  modport - spi_rx_module side: takes serial data and write-enable,
//                    publishes frame state, counters, address and strobes.
//   master modport - environment side (bus/status block, tx half, page buffer).
interface spi_rx_module_if #(
  parameter int ADDR_W = 16
);
  import spi_pkg::*;

  logic              spi_sda_in;
  logic              spi_wel;
  logic [2:0]        spi_curr_state;
  logic [2:0]        spi_bit_cnt;
  logic              spi_bitcnt_is_7;
  logic [2:0]        spi_byte_cnt;
  logic [ADDR_W-1:0] spi_curr_addr;
  logic              spi_cmd_read;
  logic              spi_cmd_rdsr;
  logic [7:0]        spi_wr_data;
  logic              spi_wr_valid;
  logic              spi_wren_set;
  logic              spi_wren_clr;
  logic              spi_cmd_err;

  modport slave (
    input  spi_sda_in, spi_wel,
    output spi_curr_state, spi_bit_cnt, spi_bitcnt_is_7, spi_byte_cnt,
           spi_curr_addr, spi_cmd_read, spi_cmd_rdsr, spi_wr_data,
           spi_wr_valid, spi_wren_set, spi_wren_clr, spi_cmd_err
  );

  modport master (
    output spi_sda_in, spi_wel,
    input  spi_curr_state, spi_bit_cnt, spi_bitcnt_is_7, spi_byte_cnt,
           spi_curr_addr, spi_cmd_read, spi_cmd_rdsr, spi_wr_data,
           spi_wr_valid, spi_wren_set, spi_wren_clr, spi_cmd_err
  );

endinterface

// File: rtl/spi_rx_shifter.sv
// spi_rx_shifter: MSB-first serial-to-parallel shifter for the SPI receive path.
//   spi_clk_c   in  - serial clock, sampling on rising edge
//   spi_frm_rst in  - asynchronous active-high frame reset
//   sda         in  - serial data
//   bit_cnt     out - bits already received in the current byte
//   byte_done   out - high during the 8th bit; the next edge completes a byte
//   rx_byte     out - byte that completes on the next edge: {shift, sda}
module spi_rx_shifter (
  input  logic       spi_clk_c,
  input  logic       spi_frm_rst,
  input  logic       sda,
  output logic [2:0] bit_cnt,
  output logic       byte_done,
  output logic [7:0] rx_byte
);

  logic [6:0] shift;

  always_ff @(posedge spi_clk_c or posedge spi_frm_rst) begin
    if (spi_frm_rst) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      shift   <= {shift[5:0], sda};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign byte_done = (bit_cnt == 3'd7);
  assign rx_byte   = {shift, sda};

endmodule

// File: rtl/spi_rx_module.sv
// spi_rx_module: serial-input half of the SPI slave.
//   spi_clk_c   in  - SPI serial clock; all state changes on its rising edge
//   spi_frm_rst in  - asynchronous active-high frame reset (chip select inactive)
//   bus         slave modport of spi_rx_module_if:
//     spi_sda_in, spi_wel                      - serial data, write-enable latch
//     spi_curr_state, spi_bit_cnt,
//     spi_bitcnt_is_7, spi_byte_cnt            - frame progress for spi_tx_module
//     spi_curr_addr                            - current byte address
//     spi_cmd_read, spi_cmd_rdsr               - command held for the frame
//     spi_wr_data, spi_wr_valid                - write byte to page buffer
//     spi_wren_set, spi_wren_clr               - write-enable latch strobes
//     spi_cmd_err                              - sticky command error
module spi_rx_module #(
  parameter int ADDR_W    = 16,
  parameter int PAGE_BITS = 5
) (
  input logic            spi_clk_c,
  input logic            spi_frm_rst,
  spi_rx_module_if.slave bus
);
  import spi_pkg::*;

  logic [2:0]        bit_cnt;
  logic              byte_done;
  logic [7:0]        rx_byte;

  spi_state_t        state;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        byte_cnt;
  logic              cmd_read;
  logic              cmd_rdsr;
  logic [7:0]        wr_data;
  logic              wr_valid;
  logic              wren_set;
  logic              wren_clr;
  logic              cmd_err;

  spi_rx_shifter u_shifter (
    .spi_clk_c   (spi_clk_c),
    .spi_frm_rst (spi_frm_rst),
    .sda         (bus.spi_sda_in),
    .bit_cnt     (bit_cnt),
    .byte_done   (byte_done),
    .rx_byte     (rx_byte)
  );

  always_ff @(posedge spi_clk_c or posedge spi_frm_rst) begin
    if (spi_frm_rst) begin
      state    <= SPI_CMD;
      addr     <= '0;
      byte_cnt <= '0;
      cmd_read <= 1'b0;
      cmd_rdsr <= 1'b0;
      wr_data  <= '0;
      wr_valid <= 1'b0;
      wren_set <= 1'b0;
      wren_clr <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      wren_set <= 1'b0;
      wren_clr <= 1'b0;

      // Write address advances one edge after the strobe so the page buffer
      // sees the byte's own address while wr_valid is high. Never coincides
      // with byte_done, since the strobe edge is the first bit of a byte.
      if (wr_valid)
        addr[PAGE_BITS-1:0] <= addr[PAGE_BITS-1:0] + PAGE_BITS'(1);

      if (byte_done) begin
        case (state)
          SPI_CMD: begin
            case (rx_byte)
              SPI_OP_READ: begin
                state    <= SPI_ADDR_HB;
                cmd_read <= 1'b1;
              end
              SPI_OP_WRITE: begin
                if (bus.spi_wel) begin
                  state <= SPI_ADDR_HB;
                end else begin
                  state   <= SPI_ERR;
                  cmd_err <= 1'b1;
                end
              end
              SPI_OP_RDSR: begin
                state    <= SPI_DAT_RD;
                cmd_rdsr <= 1'b1;
              end
              SPI_OP_WREN: begin
                state    <= SPI_WAIT;
                wren_set <= 1'b1;
              end
              SPI_OP_WRDI: begin
                state    <= SPI_WAIT;
                wren_clr <= 1'b1;
              end
              default: begin
                state   <= SPI_ERR;
                cmd_err <= 1'b1;
              end
            endcase
          end
          SPI_ADDR_HB: begin
            addr[ADDR_W-1:8] <= (ADDR_W-8)'(rx_byte);
            state            <= SPI_ADDR_LB;
          end
          SPI_ADDR_LB: begin
            addr[7:0] <= rx_byte;
            state     <= cmd_read ? SPI_DAT_RD : SPI_DAT_WR;
          end
          SPI_DAT_WR: begin
            wr_data  <= rx_byte;
            wr_valid <= 1'b1;
            byte_cnt <= byte_cnt + 3'd1;
          end
          SPI_DAT_RD: begin
            byte_cnt <= byte_cnt + 3'd1;
            // Read advances on the completing edge so the tx half can fetch
            // the next byte before its first bit is due.
            if (cmd_read)
              addr <= addr + ADDR_W'(1);
          end
          default: begin
            // SPI_WAIT / SPI_ERR hold until frame reset
          end
        endcase
      end
    end
  end

  assign bus.spi_curr_state  = state;
  assign bus.spi_bit_cnt     = bit_cnt;
  assign bus.spi_bitcnt_is_7 = byte_done;
  assign bus.spi_byte_cnt    = byte_cnt;
  assign bus.spi_curr_addr   = addr;
  assign bus.spi_cmd_read    = cmd_read;
  assign bus.spi_cmd_rdsr    = cmd_rdsr;
  assign bus.spi_wr_data     = wr_data;
  assign bus.spi_wr_valid    = wr_valid;
  assign bus.spi_wren_set    = wren_set;
  assign bus.spi_wren_clr    = wren_clr;
  assign bus.spi_cmd_err     = cmd_err;

endmodule
